isa_control_sequencer: RTL
==========================

// Module: isa_control_sequencer
// PURPOSE
//  TMP8 control FSM directly downstream of the ISA opcode bus combiner. Consumes the 8-bit
//  instruction bus (opcode in [3:0], [7:4] must be zero) and emits one-cycle control strobes.
//  Strobes drive the PC, IR, ALU, accumulator, memory and output port.
//  Sequences FETCH/DECODE/EXEC/MEM_WAIT/HALT and counts retired instructions.
// PARAMETERS
//  CNT_W      16   width of retired-instruction counter retired_cnt
//  MEM_TMO    8    max cycles in MEM_WAIT before timeout; 0 = wait forever
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  reset        in   1      synchronous, active-high
//  instr_bus    in   8      {4'b0000, opcode[3:0]} from bus combiner
//  instr_valid  in   1      instr_bus holds a fetched instruction
//  zero_flag    in   1      ALU Z flag (registered upstream)
//  carry_flag   in   1      ALU C flag (registered upstream)
//  mem_ready    in   1      memory read/write complete
//  instr_ack    out  1      1-cycle: instruction accepted into IR
//  ir_load      out  1      1-cycle IR load, coincident with instr_ack
//  pc_inc       out  1      1-cycle PC increment
//  pc_load      out  1      1-cycle PC load (taken jump)
//  alu_op       out  4      ALU function; valid while acc_load=1
//  acc_load     out  1      1-cycle accumulator write
//  mem_rd       out  1      level: read request, held until mem_ready
//  mem_wr       out  1      level: write request, held until mem_ready
//  out_load     out  1      1-cycle output-port latch
//  halted       out  1      FSM is in HALT
//  illegal      out  1      sticky; set on nonzero instr_bus[7:4] (ILLEGAL_TRAP_EN only)
//  mem_timeout  out  1      sticky; set when MEM_WAIT exceeds MEM_TMO
//  retired_cnt  out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  Reset: state=FETCH; every output 0; retired_cnt=0; sticky flags cleared. Reset wins over all.
//  Opcodes: 0 NOP 1 LDA 2 STA 3 ADD 4 SUB 5 AND 6 OR 7 XOR 8 NOT 9 JMP A JZ B JC C IN D OUT
//   E reserved(NOP) F HALT. alu_op=opcode for 3..8 and C; 4'h0 otherwise.
//  FETCH: wait instr_valid; on valid latch opcode, pulse instr_ack+ir_load+pc_inc -> DECODE.
//  DECODE: one cycle, no strobes -> EXEC, or HALT if opcode F.
//  EXEC (one cycle, strobes this cycle):
//   ALU ops 3..8, C: acc_load=1 -> FETCH
//   LDA: mem_rd=1 -> MEM_WAIT; STA: mem_wr=1 -> MEM_WAIT
//   JMP: pc_load=1; JZ if zero_flag; JC if carry_flag; D: out_load=1; 0/E: none -> FETCH
//  MEM_WAIT: hold mem_rd/mem_wr; on mem_ready drop request (LDA also pulses acc_load with
//   alu_op=0 pass-through) -> FETCH. mem_ready in the EXEC cycle is ignored.
//  Timeout: MEM_TMO>0 and wait count reaches MEM_TMO: set mem_timeout, drop request -> HALT.
//  HALT: absorbing, halted=1, all strobes 0, instr_valid ignored; exit only by reset.
//  Latency: ALU/jump/NOP = 3 cycles FETCH-accept to next FETCH; memory = 3 + wait cycles.
//  retired_cnt += 1 on each return to FETCH from EXEC or MEM_WAIT; wraps 2^CNT_W-1 -> 0.
//  Timeout/HALT entry does not retire. Flags are sampled only in EXEC.
//  instr_bus is sampled only in the FETCH accept cycle; later changes are ignored.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: instr_bus[7:4]!=0 at accept -> ack/ir_load/pc_inc still pulse,
//   then set illegal, DECODE -> HALT, no retire.
//  ILLEGAL_TRAP_EN undefined: instr_bus[7:4] ignored (decode [3:0] only); illegal tied to 0.
// TESTING
//  Reset, then ADD (8'h03) valid -> ack @c1; acc_load=1, alu_op=3 @c3; retired_cnt=1.
//  LDA (8'h01), mem_ready low 4 cycles -> mem_rd held 5 cycles; acc_load 1 cycle on ready.
//  JZ (8'h0A) with zero_flag=0 then 1 -> no pc_load, then pc_load=1; retired_cnt=2.
//  HALT (8'h0F) then instr_valid=1 -> halted=1, no further acks; reset -> FETCH, cnt=0.
//  STA with MEM_TMO=8, mem_ready never -> mem_timeout=1, halted=1, mem_wr dropped.
//  ILLEGAL_TRAP_EN, instr_bus=8'h13 -> illegal=1, HALT; without macro executes ADD.

Source files
------------

// File: rtl/isa_control_sequencer_if.sv
// Bundle of the TMP8 sequencer's instruction, flag, memory and strobe signals.
// The sequencer connects through slave; the driving environment connects through master.
interface isa_control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       instr_bus;
    logic             instr_valid;
    logic             zero_flag;
    logic             carry_flag;
    logic             mem_ready;
    logic             instr_ack;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_load;
    logic [3:0]       alu_op;
    logic             acc_load;
    logic             mem_rd;
    logic             mem_wr;
    logic             out_load;
    logic             halted;
    logic             illegal;
    logic             mem_timeout;
    logic [CNT_W-1:0] retired_cnt;

    modport slave (
        input  instr_bus, instr_valid, zero_flag, carry_flag, mem_ready,
        output instr_ack, ir_load, pc_inc, pc_load, alu_op, acc_load,
               mem_rd, mem_wr, out_load, halted, illegal, mem_timeout, retired_cnt
    );

    modport master (
        output instr_bus, instr_valid, zero_flag, carry_flag, mem_ready,
        input  instr_ack, ir_load, pc_inc, pc_load, alu_op, acc_load,
               mem_rd, mem_wr, out_load, halted, illegal, mem_timeout, retired_cnt
    );
endinterface

// File: rtl/isa_control_sequencer.sv
// TMP8 control FSM: FETCH/DECODE/EXEC/MEM_WAIT/HALT with one-cycle strobes and retire counter.
// Optional ILLEGAL_TRAP_EN: nonzero instr_bus[7:4] at accept traps to HALT and sets illegal.
module isa_control_sequencer #(
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    isa_control_sequencer_if.slave bus
);
    localparam int TMO_W = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TMO > 0) ? MEM_TMO - 1 : 0);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_HALT
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       opcode_reg, opcode_next;
    logic [TMO_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic             timeout_reg, timeout_next;
    logic             illegal_reg, illegal_next;
    logic             trap_reg, trap_next;
    logic             bad_bus;

    logic       ack_c, pc_inc_c, pc_load_c, acc_load_c;
    logic       mem_rd_c, mem_wr_c, out_load_c, halted_c;
    logic [3:0] alu_op_c;

    // Opcodes that write the accumulator straight from the ALU in EXEC.
    logic [15:0] alu_class;
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_alu_class
            assign alu_class[gi] = ((gi >= 3) && (gi <= 8)) || (gi == 12);
        end
    endgenerate

`ifdef ILLEGAL_TRAP_EN
    assign bad_bus     = |bus.instr_bus[7:4];
    assign bus.illegal = illegal_reg;
`else
    logic unused_hi;
    assign unused_hi   = ^bus.instr_bus[7:4];
    assign bad_bus     = 1'b0;
    assign bus.illegal = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        opcode_next  = opcode_reg;
        wait_next    = '0;
        retired_next = retired_reg;
        timeout_next = timeout_reg;
        illegal_next = illegal_reg;
        trap_next    = trap_reg;
        ack_c        = 1'b0;
        pc_inc_c     = 1'b0;
        pc_load_c    = 1'b0;
        acc_load_c   = 1'b0;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        out_load_c   = 1'b0;
        halted_c     = 1'b0;
        alu_op_c     = 4'h0;
        unique case (state_reg)
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    ack_c        = 1'b1;
                    pc_inc_c     = 1'b1;
                    opcode_next  = bus.instr_bus[3:0];
                    trap_next    = bad_bus;
                    illegal_next = illegal_reg | bad_bus;
                    state_next   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = (trap_reg || opcode_reg == 4'hF) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                state_next   = ST_FETCH;
                retired_next = retired_reg + CNT_W'(1);
                if (alu_class[opcode_reg]) begin
                    acc_load_c = 1'b1;
                    alu_op_c   = opcode_reg;
                end
                case (opcode_reg)
                    4'h1, 4'h2: begin
                        mem_rd_c     = (opcode_reg == 4'h1);
                        mem_wr_c     = (opcode_reg == 4'h2);
                        retired_next = retired_reg;
                        state_next   = ST_MEM_WAIT;
                    end
                    4'h9:    pc_load_c  = 1'b1;
                    4'hA:    pc_load_c  = bus.zero_flag;
                    4'hB:    pc_load_c  = bus.carry_flag;
                    4'hD:    out_load_c = 1'b1;
                    default: ;
                endcase
            end
            ST_MEM_WAIT: begin
                // Request stays up through the cycle in which mem_ready is seen.
                mem_rd_c = (opcode_reg == 4'h1);
                mem_wr_c = (opcode_reg != 4'h1);
                if (bus.mem_ready) begin
                    acc_load_c   = (opcode_reg == 4'h1);
                    retired_next = retired_reg + CNT_W'(1);
                    state_next   = ST_FETCH;
                end else if ((MEM_TMO > 0) && (wait_reg == TMO_LAST)) begin
                    timeout_next = 1'b1;
                    state_next   = ST_HALT;
                end else begin
                    wait_next = wait_reg + TMO_W'(1);
                end
            end
            ST_HALT: halted_c = 1'b1;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            opcode_reg  <= 4'h0;
            wait_reg    <= '0;
            retired_reg <= '0;
            timeout_reg <= 1'b0;
            illegal_reg <= 1'b0;
            trap_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            opcode_reg  <= opcode_next;
            wait_reg    <= wait_next;
            retired_reg <= retired_next;
            timeout_reg <= timeout_next;
            illegal_reg <= illegal_next;
            trap_reg    <= trap_next;
        end
    end

    // Strobes are decoded from the current state, so force them low while reset is held.
    assign bus.instr_ack   = ack_c & ~reset;
    assign bus.ir_load     = ack_c & ~reset;
    assign bus.pc_inc      = pc_inc_c & ~reset;
    assign bus.pc_load     = pc_load_c & ~reset;
    assign bus.acc_load    = acc_load_c & ~reset;
    assign bus.alu_op      = reset ? 4'h0 : alu_op_c;
    assign bus.mem_rd      = mem_rd_c & ~reset;
    assign bus.mem_wr      = mem_wr_c & ~reset;
    assign bus.out_load    = out_load_c & ~reset;
    assign bus.halted      = halted_c & ~reset;
    assign bus.mem_timeout = timeout_reg;
    assign bus.retired_cnt = retired_reg;
endmodule
